writeback_unit: RTL
===================

# writeback_unit

- Write-back stage of the RISC-V core, sitting directly upstream of the register file.
- Accepts ALU results and in-flight load responses, formats load data, and serialises both onto the register file's single write port (`write`, `c_address`, `c_in`).
- Tracks one outstanding load and produces operand bypass data plus a stall for the read stage.

## Interface
Parameters: none (XLEN fixed at 32).
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `alu_valid` in 1, `alu_ready` out 1: ALU result handshake.
- `alu_rd` in 5, `alu_result` in 32: ALU destination and value.
- `load_issue` in 1, `load_ready` out 1: load-issue handshake.
- `load_rd` in 5, `load_funct3` in 3, `load_offset` in 2: load destination, type, and address bits [1:0].
- `mem_valid` in 1, `mem_rdata` in 32: memory read response (aligned 32-bit word).
- `rs1` in 5, `rs2` in 5: read-stage source addresses (same values that drive the register file `a_address`/`b_address`).
- `rf_a_data` in 32, `rf_b_data` in 32: register file `a_out`/`b_out`.
- `a_data` out 32, `b_data` out 32: operands delivered to execute.
- `stall` out 1: read stage must hold.
- `write` out 1, `c_address` out 5, `c_in` out 32: register file write port, all registered.

## Operation
- FSM states: IDLE, LOAD_WAIT, LOAD_WB.
- IDLE:
  - `load_issue && load_ready` captures `load_rd`, `load_funct3`, and `load_offset` into the pending registers and moves to LOAD_WAIT.
  - `mem_valid` is ignored.
- LOAD_WAIT: `mem_valid` latches the formatted data and moves to LOAD_WB.
- LOAD_WB:
  - Registers the load write and returns to IDLE.
  - `mem_valid` is ignored.
- Ready signals (combinational):
  - `load_ready` = (state == IDLE).
  - `alu_ready` = (state != LOAD_WB).
- An ALU result may be accepted in the same cycle as a load issue; both proceed.
- Write-port update each edge:
  - LOAD_WB: write the pending load.
  - Else, accepted ALU beat: write `alu_rd`/`alu_result`.
  - Else: `write` = 0, `c_address`/`c_in` hold their previous values.
- Any write whose rd == 0 drives `write` = 0. A load to x0 still consumes its memory response.
- Load formatting by funct3:
  - 000 LB: sign-extend byte `load_offset`.
  - 001 LH: sign-extend halfword `load_offset[1]`.
  - 100 LBU / 101 LHU: zero-extended equivalents.
  - 010 and all other encodings: full word.
  - `load_offset` is ignored for word loads.
- Stall is asserted when either of these holds:
  - State != IDLE, pending rd != 0, and pending rd equals `rs1` or `rs2`.
  - Bypass rule per Configuration.
- `rs` == 0 never stalls and never bypasses.
- Reset: state IDLE; pending registers, `write`, `c_address`, and `c_in` all 0.
  - Reset mid-load abandons the load; a later `mem_valid` in IDLE is ignored.

## Timing
- ALU beat accepted at edge N: `write`/`c_*` are valid after N, and the register file captures at N+1.
- Earliest `mem_valid` is the cycle after issue. `mem_valid` in the issue cycle is ignored.
- `mem_valid` at edge M: LOAD_WB after M, load write driven after M+1, register file updated at M+2.
- Minimum load turnaround: issue to next `load_ready` takes 3 cycles.
- `alu_ready` is low for exactly one cycle per load (LOAD_WB).
- `stall`, `a_data`, and `b_data` are combinational from the current state and registered outputs.

## Configuration
- `WB_BYPASS_EN` defined: when `write` = 1 and `c_address` == `rs1` (or `rs2`), the matching `a_data`/`b_data` equals `c_in`; no stall for that case.
- `WB_BYPASS_EN` undefined:
  - `a_data` = `rf_a_data` and `b_data` = `rf_b_data` always.
  - That same match asserts `stall` for one cycle.

## Structure
- Shared `riscv_pkg` holds:
  - Load funct3 localparams (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`).
  - The `wb_state_t` enum.
- Sub-module `load_formatter`: purely combinational (funct3, offset, rdata -> 32-bit value), instantiated once.

## Test plan
- ALU beat: rd = 5, result 0xDEADBEEF -> `write` = 1, `c_address` = 5, `c_in` = 0xDEADBEEF one cycle after acceptance; x0 beat -> `write` = 0.
- Load formats: rdata 0x80FF7F01 with LB offset 3 -> 0xFFFFFF80; LBU offset 1 -> 0x0000007F; LH offset 2 -> 0xFFFF80FF; LW -> 0x80FF7F01.
- Simultaneous load issue and ALU beat, then `mem_valid` -> ALU write first, `alu_ready` = 0 during LOAD_WB, load write next, no lost beats.
- Load to rd = 7 pending, `rs1` = 7 -> `stall` = 1 until the write cycle; `rs2` = 0 never stalls.
- Back-to-back write rd = 3, `rs2` = 3: with `WB_BYPASS_EN`, `b_data` = `c_in` and `stall` = 0; without it, `stall` = 1 for one cycle.
- Reset asserted in LOAD_WAIT, then `mem_valid` pulses -> all outputs 0, state IDLE, no write.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the core's pipeline stages.
//   - Load funct3 encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
//   - wb_state_t: write-back stage load tracking FSM states
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        LOAD_WB   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/load_formatter.sv
// load_formatter: extracts and extends load data from an aligned 32-bit word.
// Purely combinational.
//   funct3 in 3  : load type (LB/LH/LW/LBU/LHU; other encodings treated as word)
//   offset in 2  : address bits [1:0]; ignored for word loads
//   rdata  in 32 : aligned memory word
//   data   out 32: formatted register value
module load_formatter
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        // Halfword selection only looks at offset[1]; offset[0] is a
        // misalignment the upstream stage is responsible for.
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: write-back stage in front of the register file.
// Serialises ALU results and one outstanding load onto the register file's
// single write port, and gives the read stage operand data plus a stall.
//
// Ports:
//   clock, reset             : clock, asynchronous active-high reset
//   alu_valid/alu_ready      : ALU result handshake (alu_rd, alu_result)
//   load_issue/load_ready    : load issue handshake (load_rd, load_funct3, load_offset)
//   mem_valid, mem_rdata     : memory read response (aligned word)
//   rs1, rs2                 : read-stage source register addresses
//   rf_a_data, rf_b_data     : register file read data
//   a_data, b_data           : operands to execute
//   stall                    : read stage must hold
//   write, c_address, c_in   : registered register file write port
//
// Build option: WB_BYPASS_EN -- when defined, a write sitting on the port
// is forwarded to matching operands instead of stalling the read stage.
module writeback_unit
    import riscv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            load_issue,
    output logic            load_ready,
    input  logic [4:0]      load_rd,
    input  logic [2:0]      load_funct3,
    input  logic [1:0]      load_offset,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] rf_a_data,
    input  logic [XLEN-1:0] rf_b_data,
    output logic [XLEN-1:0] a_data,
    output logic [XLEN-1:0] b_data,
    output logic            stall,
    output logic            write,
    output logic [4:0]      c_address,
    output logic [XLEN-1:0] c_in
);

    wb_state_t       state_q, state_d;
    logic [4:0]      pend_rd_q, pend_rd_d;
    logic [2:0]      pend_f3_q, pend_f3_d;
    logic [1:0]      pend_off_q, pend_off_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            write_q, write_d;
    logic [4:0]      c_address_q, c_address_d;
    logic [XLEN-1:0] c_in_q, c_in_d;

    logic [XLEN-1:0] fmt_data;
    logic            alu_fire;
    logic            load_hazard;
    logic            hit_a, hit_b;

    // Formats the response against the captured load type, so the pending
    // register holds a final register value by the time LOAD_WB runs.
    load_formatter u_fmt (
        .funct3 (pend_f3_q),
        .offset (pend_off_q),
        .rdata  (mem_rdata),
        .data   (fmt_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_rd_q   <= '0;
            pend_f3_q   <= '0;
            pend_off_q  <= '0;
            load_data_q <= '0;
            write_q     <= 1'b0;
            c_address_q <= '0;
            c_in_q      <= '0;
        end else begin
            state_q     <= state_d;
            pend_rd_q   <= pend_rd_d;
            pend_f3_q   <= pend_f3_d;
            pend_off_q  <= pend_off_d;
            load_data_q <= load_data_d;
            write_q     <= write_d;
            c_address_q <= c_address_d;
            c_in_q      <= c_in_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_rd_d   = pend_rd_q;
        pend_f3_d   = pend_f3_q;
        pend_off_d  = pend_off_q;
        load_data_d = load_data_q;
        write_d     = 1'b0;
        c_address_d = c_address_q;
        c_in_d      = c_in_q;

        load_ready = (state_q == IDLE);
        // The write port belongs to the load during LOAD_WB only.
        alu_ready  = (state_q != LOAD_WB);
        alu_fire   = alu_valid && alu_ready;

        case (state_q)
            IDLE: begin
                if (load_issue) begin
                    pend_rd_d  = load_rd;
                    pend_f3_d  = load_funct3;
                    pend_off_d = load_offset;
                    state_d    = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (mem_valid) begin
                    load_data_d = fmt_data;
                    state_d     = LOAD_WB;
                end
            end
            LOAD_WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // x0 writes still move the address/data, but never raise write.
        if (state_q == LOAD_WB) begin
            write_d     = (pend_rd_q != 5'd0);
            c_address_d = pend_rd_q;
            c_in_d      = load_data_q;
        end else if (alu_fire) begin
            write_d     = (alu_rd != 5'd0);
            c_address_d = alu_rd;
            c_in_d      = alu_result;
        end
    end

    // A nonzero pending rd can only match nonzero sources, so rs == 0
    // never stalls. The same holds for write_q, which implies c_address != 0.
    always_comb begin
        load_hazard = (state_q != IDLE) && (pend_rd_q != 5'd0) &&
                      ((pend_rd_q == rs1) || (pend_rd_q == rs2));
        hit_a = write_q && (c_address_q == rs1);
        hit_b = write_q && (c_address_q == rs2);
`ifdef WB_BYPASS_EN
        a_data = hit_a ? c_in_q : rf_a_data;
        b_data = hit_b ? c_in_q : rf_b_data;
        stall  = load_hazard;
`else
        // Register file has not captured the write yet: hold one cycle.
        a_data = rf_a_data;
        b_data = rf_b_data;
        stall  = load_hazard || hit_a || hit_b;
`endif
    end

    assign write     = write_q;
    assign c_address = c_address_q;
    assign c_in      = c_in_q;

endmodule
